// File: rtl/fle_if.sv
// fle_if: operand/result bundle for the binary32 less-or-equal comparator.
// The exception wire exists only when FLE_EXCEPTION_EN is defined.
interface fle_if;
  logic        in_valid;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        y;
`ifdef FLE_EXCEPTION_EN
  logic        exception;

  modport master (output in_valid, x1, x2, input out_valid, y, exception);
  modport slave  (input in_valid, x1, x2, output out_valid, y, exception);
`else
  modport master (output in_valid, x1, x2, input out_valid, y);
  modport slave  (input in_valid, x1, x2, output out_valid, y);
`endif
endinterface

// File: rtl/fle.sv
// fle: IEEE-754 binary32 ordered compare y = (x1 <= x2), one-cycle registered.
// Optional feature: define FLE_EXCEPTION_EN to add the registered exception
// output, which flags a NaN on either operand (quiet or signaling).
module fle (
  input  logic clk,
  input  logic rstn,
  fle_if.slave bus
);

  logic [31:0] a;
  logic [31:0] b;
  logic        a_nan;
  logic        b_nan;
  logic        both_zero;
  logic        le;

  assign a = bus.x1;
  assign b = bus.x2;

  // Operand classification: NaN has all-ones exponent with a non-zero mantissa.
  assign a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

  // Priority-ordered compare; sign-magnitude encoding orders positive values
  // by raw magnitude and negative values by reversed magnitude.
  always_comb begin
    // NOTE: default assignment first so every path drives le and no latch is inferred.
    le = 1'b0;
    if (a_nan || b_nan) begin
      le = 1'b0;
    end else if (both_zero) begin
      le = 1'b1;
    end else if (a[31] != b[31]) begin
      le = a[31];
    end else if (!a[31]) begin
      le = (a[30:0] <= b[30:0]);
    end else begin
      le = (a[30:0] >= b[30:0]);
    end
  end

  // Result register: out_valid tracks in_valid; result holds across gaps.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rstn) begin
      bus.out_valid <= 1'b0;
      bus.y         <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.y <= le;
      end
    end
  end

`ifdef FLE_EXCEPTION_EN
  // Invalid-operand flag, registered with the same timing as y.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.exception <= 1'b0;
    end else if (bus.in_valid) begin
      bus.exception <= a_nan || b_nan;
    end
  end
`endif

endmodule

// File: tb/tb_fle.sv
// tb_fle: directed and swept checks of the fle binary32 <= comparator.
// Exception checks are compiled in when FLE_EXCEPTION_EN is defined.
module tb_fle;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fle_if bus ();

  fle dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Maps a non-NaN binary32 pattern onto an unsigned key with the same order.
  function automatic logic [31:0] order_key(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    if (t[30:0] == 31'd0) t = 32'd0;
    return t[31] ? ~t : (t | 32'h8000_0000);
  endfunction

  function automatic logic ref_le(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    return order_key(a) <= order_key(b);
  endfunction

  // One valid compare: drive at negedge, sample 1 time unit after the edge.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic exp_y, input logic exp_exc);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x1       = a;
    bus.x2       = b;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, ".y"}, {31'd0, bus.y}, {31'd0, exp_y});
`ifdef FLE_EXCEPTION_EN
    check({tag, ".exc"}, {31'd0, bus.exception}, {31'd0, exp_exc});
`else
    if (exp_exc === 1'bx) $display("unexpected x on expected exception");
`endif
  endtask

  logic [22:0] corners [7];
  logic [31:0] ops_a;
  logic [31:0] ops_b;

  initial begin
    corners = '{23'h000000, 23'h000001, 23'h000002, 23'h380000,
                23'h400000, 23'h5FFFFF, 23'h7FFFFF};
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    bus.x1       = 32'd0;
    bus.x2       = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset.y", {31'd0, bus.y}, 32'd0);
`ifdef FLE_EXCEPTION_EN
    check("reset.exc", {31'd0, bus.exception}, 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    // Directed vectors, hand-computed.
    run("one_le_two",  32'h3F800000, 32'h40000000, 1'b1, 1'b0);
    run("two_le_one",  32'h40000000, 32'h3F800000, 1'b0, 1'b0);
    run("one_eq",      32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
    run("nz_le_pz",    32'h80000000, 32'h00000000, 1'b1, 1'b0);
    run("pz_le_nz",    32'h00000000, 32'h80000000, 1'b1, 1'b0);
    run("m1_le_m2",    32'hBF800000, 32'hC0000000, 1'b0, 1'b0);
    run("m2_le_m1",    32'hC0000000, 32'hBF800000, 1'b1, 1'b0);
    run("sub_1_2",     32'h00000001, 32'h00000002, 1'b1, 1'b0);
    run("nsub_le_z",   32'h80000001, 32'h00000000, 1'b1, 1'b0);
    run("nsub_big",    32'h807FFFFF, 32'h80000001, 1'b1, 1'b0);
    run("ninf_pinf",   32'hFF800000, 32'h7F800000, 1'b1, 1'b0);
    run("pinf_max",    32'h7F800000, 32'h7F7FFFFF, 1'b0, 1'b0);
    run("pinf_pinf",   32'h7F800000, 32'h7F800000, 1'b1, 1'b0);
    run("qnan_z",      32'h7FC00000, 32'h00000000, 1'b0, 1'b1);
    run("z_snan",      32'h00000000, 32'hFF800001, 1'b0, 1'b1);
    run("nan_nan",     32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1);
    run("z_le_ninf",   32'h00000000, 32'hFF800000, 1'b0, 1'b0);

    // Reset wins over a simultaneous in_valid (previous y was 0, so set y=1 first).
    run("pre_rst",     32'h3F800000, 32'h40000000, 1'b1, 1'b0);
    @(negedge clk);
    rstn         = 1'b0;
    bus.in_valid = 1'b1;
    bus.x1       = 32'h3F800000;
    bus.x2       = 32'h40000000;
    @(posedge clk);
    #1;
    check("rst_mid.valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid.y", {31'd0, bus.y}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run("post_rst",    32'hC0000000, 32'hBF800000, 1'b1, 1'b0);

    // in_valid gap: out_valid drops, y holds although inputs would give 0.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x1       = 32'h40000000;
    bus.x2       = 32'h3F800000;
    @(posedge clk);
    #1;
    check("gap.valid", {31'd0, bus.out_valid}, 32'd0);
    check("gap.y_hold", {31'd0, bus.y}, 32'd1);
    run("after_gap",   32'h40000000, 32'h3F800000, 1'b0, 1'b0);

    // Sweep: every exponent, both signs, corner and random mantissas,
    // against an equal-exponent partner and a random partner.
    for (int e = 0; e < 256; e++) begin
      for (int s = 0; s < 2; s++) begin
        for (int m = 0; m < 8; m++) begin
          logic [22:0] man;
          logic [31:0] r;
          man   = (m < 7) ? corners[m] : 23'($urandom);
          ops_a = {s[0], e[7:0], man};
          r     = $urandom;
          ops_b = {r[31], e[7:0], (man & 23'h7FF000) | {11'd0, r[11:0]}};
          run("sweep_eqexp", ops_a, ops_b, ref_le(ops_a, ops_b),
              is_nan(ops_a) || is_nan(ops_b));
          r     = $urandom;
          ops_b = {r[31], r[30:23], corners[r[2:0] % 7]};
          run("sweep_mixed", ops_b, ops_a, ref_le(ops_b, ops_a),
              is_nan(ops_a) || is_nan(ops_b));
        end
      end
    end

    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
